// File: rtl/tmds_symbol_serializer_pkg.sv
// Shared TMDS symbol definitions: symbol width, control-period symbols and symbol type.
package tmds_pkg;

    localparam int unsigned TMDS_SYMBOL_W = 10;

    typedef logic [TMDS_SYMBOL_W-1:0] tmds_sym_t;

    // Control-period symbols, indexed by {C1,C0}
    localparam tmds_sym_t CTL00 = 10'b1101010100;
    localparam tmds_sym_t CTL01 = 10'b0010101011;
    localparam tmds_sym_t CTL10 = 10'b0101010100;
    localparam tmds_sym_t CTL11 = 10'b1010101011;

endpackage

// File: rtl/tmds_symbol_serializer_fifo.sv
// Small synchronous FIFO holding whole multi-channel symbol words.
// Head word is read straight from the storage flops; a push into an empty
// FIFO is only visible at the head after the edge that wrote it.
module tmds_sym_fifo #(
    parameter int unsigned WIDTH = 30,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage write; guarded by full so a held word is never overwritten
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update; extra MSB distinguishes full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tmds_symbol_serializer.sv
// Multi-channel TMDS symbol serializer: FIFO-buffered symbol words shifted out
// LSB-first, OUT_BITS per channel per clock, with idle-symbol insertion on underrun.
module tmds_symbol_serializer
    import tmds_pkg::*;
#(
    parameter int unsigned         NUM_CH     = 3,
    parameter int unsigned         SYMBOL_W   = 10,
    parameter int unsigned         OUT_BITS   = 1,
    parameter int unsigned         FIFO_DEPTH = 4,
    parameter logic [SYMBOL_W-1:0] IDLE_SYM   = CTL00,
    parameter int unsigned         CNT_W      = 16
) (
    input  logic                         i_tmds_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic [NUM_CH*SYMBOL_W-1:0]   i_symbols,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic [NUM_CH*OUT_BITS-1:0]   o_tmds,
    output logic                         o_load,
    output logic                         o_underrun,
    output logic [CNT_W-1:0]             o_underrun_cnt
);

    localparam int unsigned RATIO = SYMBOL_W / OUT_BITS;
    localparam int unsigned PH_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(RATIO - 1);

    if ((SYMBOL_W % OUT_BITS) != 0) begin : g_bad_out_bits
        $error("OUT_BITS must divide SYMBOL_W");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    logic [PH_W-1:0]              phase;
    logic                         load_edge;
    logic                         push;
    logic                         pop;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [NUM_CH*SYMBOL_W-1:0]   head;

    assign load_edge = i_en && (phase == LAST_PH);
    assign o_ready   = !i_rst && !fifo_full;
    assign push      = i_valid && o_ready;
    // Pop is decided from the pre-edge empty flag, so a same-edge push into an
    // empty FIFO waits for the next load and the idle symbol goes out instead.
    assign pop       = load_edge && !fifo_empty;

    tmds_sym_fifo #(
        .WIDTH (NUM_CH * SYMBOL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_tmds_clk),
        .rst     (i_rst),
        .push    (push),
        .pop     (pop),
        .wr_data (i_symbols),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Phase counter; reset to the last phase so the first enabled edge loads
    always_ff @(posedge i_tmds_clk) begin
        if (i_rst) begin
            phase <= LAST_PH;
        end else if (i_en) begin
            phase <= (phase == LAST_PH) ? '0 : phase + 1'b1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SYMBOL_W-1:0] shreg;

        // Per-channel shift register: load head or idle symbol, else shift right
        always_ff @(posedge i_tmds_clk) begin
            if (i_rst) begin
                shreg <= '0;
            end else if (load_edge) begin
                shreg <= fifo_empty ? IDLE_SYM : head[c*SYMBOL_W +: SYMBOL_W];
            end else if (i_en) begin
                shreg <= shreg >> OUT_BITS;
            end
        end

        assign o_tmds[c*OUT_BITS +: OUT_BITS] = shreg[OUT_BITS-1:0];
    end

    // Load/underrun pulses and saturating underrun counter
    always_ff @(posedge i_tmds_clk) begin
        if (i_rst) begin
            o_load         <= 1'b0;
            o_underrun     <= 1'b0;
            o_underrun_cnt <= '0;
        end else begin
            o_load     <= load_edge;
            o_underrun <= load_edge && fifo_empty;
            if (load_edge && fifo_empty && (o_underrun_cnt != '1)) begin
                o_underrun_cnt <= o_underrun_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tmds_symbol_serializer.sv
// Self-checking bench: default-parameter DUT checked every cycle against a
// bit-index/queue reference model; extra instances cover OUT_BITS=2/5 and CNT_W=2.
module tb_tmds_symbol_serializer;
    import tmds_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        valid;
    logic        valid_aux;
    logic [29:0] symbols;

    logic        ready,  load,  urun;
    logic [2:0]  tmds;
    logic [15:0] cnt;
    logic        ready2, load2, urun2;
    logic [5:0]  tmds2;
    logic [15:0] cnt2;
    logic        ready5, load5, urun5;
    logic [14:0] tmds5;
    logic [1:0]  cnt5;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    tmds_symbol_serializer dut (
        .i_tmds_clk(clk), .i_rst(rst), .i_en(en), .i_symbols(symbols), .i_valid(valid),
        .o_ready(ready), .o_tmds(tmds), .o_load(load), .o_underrun(urun), .o_underrun_cnt(cnt)
    );

    tmds_symbol_serializer #(.OUT_BITS(2)) dut2 (
        .i_tmds_clk(clk), .i_rst(rst), .i_en(en), .i_symbols(symbols), .i_valid(valid_aux),
        .o_ready(ready2), .o_tmds(tmds2), .o_load(load2), .o_underrun(urun2), .o_underrun_cnt(cnt2)
    );

    tmds_symbol_serializer #(.OUT_BITS(5), .CNT_W(2)) dut5 (
        .i_tmds_clk(clk), .i_rst(rst), .i_en(en), .i_symbols(symbols), .i_valid(valid_aux),
        .o_ready(ready5), .o_tmds(tmds5), .o_load(load5), .o_underrun(urun5), .o_underrun_cnt(cnt5)
    );

    // Reference model state: queued words, current symbol word, bit index within it
    logic [29:0] q[$];
    logic [29:0] cur;
    int unsigned k;
    int unsigned n_en;
    bit          loaded;
    logic [15:0] m_cnt;
    bit          m_load;
    bit          m_urun;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled
    task automatic model_edge();
        bit do_push;
        if (rst) begin
            q.delete();
            n_en   = 0;
            k      = 0;
            loaded = 0;
            m_cnt  = '0;
            m_load = 0;
            m_urun = 0;
        end else begin
            do_push = valid && (q.size() < 4);
            m_load  = 0;
            m_urun  = 0;
            if (en) begin
                if (n_en % 10 == 0) begin
                    m_load = 1;
                    if (q.size() > 0) begin
                        cur = q.pop_front();
                    end else begin
                        cur    = {CTL00, CTL00, CTL00};
                        m_urun = 1;
                        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    end
                    loaded = 1;
                    k      = 0;
                end else begin
                    k++;
                end
                n_en++;
            end
            if (do_push) q.push_back(symbols);
        end
    endtask

    task automatic tick();
        logic [2:0] et;
        model_edge();
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) et[c] = loaded ? cur[c*10 + int'(k)] : 1'b0;
        chk("tmds",  64'(tmds),  64'(et));
        chk("load",  64'(load),  64'(m_load));
        chk("urun",  64'(urun),  64'(m_urun));
        chk("cnt",   64'(cnt),   64'(m_cnt));
        chk("ready", 64'(ready), 64'(!rst && (q.size() < 4)));
    endtask

    initial begin
        logic [9:0]  sym;
        logic [9:0]  idle;
        int unsigned w;
        bit          acc;
        sym  = 10'h3A5;
        idle = CTL00;

        rst = 1'b1; en = 1'b0; valid = 1'b0; valid_aux = 1'b0; symbols = '0;
        tick(); tick();

        // One word after reset: idle symbol first, then the word
        rst = 1'b0; en = 1'b1; valid = 1'b1;
        symbols = {10'h2AA, 10'h155, 10'h0FF};
        tick();
        valid = 1'b0;
        repeat (24) tick();

        // No input: continuous idle symbols and underruns
        repeat (30) tick();

        // Source held valid with incrementing data: fill, throttle, drain in order
        w = 0;
        valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            symbols = {10'(w*3 + 2), 10'(w*3 + 1), 10'(w*3)};
            acc = ready;
            tick();
            if (acc) w++;
        end
        valid = 1'b0;
        repeat (50) tick();

        // Enable dropped mid-symbol for 7 cycles while pushes continue
        valid = 1'b1; symbols = 30'h1234_5678;
        tick();
        valid = 1'b0;
        repeat (13) tick();
        en = 1'b0; valid = 1'b1; symbols = 30'h0ABC_DEF1;
        repeat (7) tick();
        valid = 1'b0; en = 1'b1;
        repeat (25) tick();

        // Reset at phase 4 with 3 words queued
        rst = 1'b1; tick();
        rst = 1'b0; en = 1'b0; valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            symbols = {10'(i + 100), 10'(i + 200), 10'(i + 300)};
            tick();
        end
        valid = 1'b0; en = 1'b1;
        tick();
        repeat (4) tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (15) tick();

        // OUT_BITS=2 and OUT_BITS=5 instances: idle then 10'h3A5 on channel 0
        rst = 1'b1; tick();
        rst = 1'b0; en = 1'b1; symbols = {20'h0, sym}; valid_aux = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            valid_aux = 1'b0;
            chk("load2", 64'(load2), 64'(e % 5 == 0));
            chk("load5", 64'(load5), 64'(e % 2 == 0));
            if (e < 5) chk("idle2", 64'(tmds2[1:0]), 64'((idle >> (2*e)) & 10'd3));
            else       chk("slice2", 64'(tmds2[1:0]), 64'((sym >> (2*(e-5))) & 10'd3));
            if (e < 2)      chk("idle5", 64'(tmds5[4:0]), 64'((idle >> (5*e)) & 10'd31));
            else if (e < 4) chk("slice5", 64'(tmds5[4:0]), 64'((sym >> (5*(e-2))) & 10'd31));
        end

        // CNT_W=2 instance: underrun count saturates at 3
        rst = 1'b1; tick();
        chk("cnt5_rst", 64'(cnt5), 64'(0));
        rst = 1'b0; en = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            tick();
            chk("urun5", 64'(urun5), 64'(e % 2 == 0));
            chk("cnt5", 64'(cnt5), 64'((e/2 + 1 > 3) ? 3 : e/2 + 1));
        end

        // Randomized traffic with occasional resets and enable gaps
        for (int i = 0; i < 800; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            en      = ($urandom_range(0, 7) != 0);
            valid   = $urandom_range(0, 1) == 1;
            symbols = 30'($urandom());
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
